// File: rtl/wino_pkg.sv
// wino_pkg: tile geometry and pipeline latency for the Winograd input transform.
// Define WINO_BTDB_IN_REG_EN to add an input register stage (latency 2).
package wino_pkg;
  localparam int WINO_ROWS = 4;
  localparam int WINO_COLS = 3;
  localparam int WINO_TILE = WINO_ROWS * WINO_COLS;
`ifdef WINO_BTDB_IN_REG_EN
  localparam int WINO_LAT = 2;
`else
  localparam int WINO_LAT = 1;
`endif
endpackage

// File: rtl/wino_bt4_1d.sv
// wino_bt4_1d: combinational 4-point F(2,3) B^T transform of one tile column, wrapping arithmetic.
module wino_bt4_1d #(
  parameter int data_width = 20
) (
  input  logic [data_width-1:0] i_d0,
  input  logic [data_width-1:0] i_d1,
  input  logic [data_width-1:0] i_d2,
  input  logic [data_width-1:0] i_d3,
  output logic [data_width-1:0] o_u0,
  output logic [data_width-1:0] o_u1,
  output logic [data_width-1:0] o_u2,
  output logic [data_width-1:0] o_u3
);
  assign o_u0 = i_d0 - i_d2;
  assign o_u1 = i_d1 + i_d2;
  assign o_u2 = i_d2 - i_d1;
  assign o_u3 = i_d1 - i_d3;
endmodule

// File: rtl/wino_btdb_22_32_xform.sv
// wino_btdb_22_32_xform: Winograd input transform V = B4^T.D.B3 for a 4x3 tile, one tile per cycle.
// Define WINO_BTDB_IN_REG_EN to register din/in_valid before the arithmetic (latency 2).
module wino_btdb_22_32_xform
  import wino_pkg::*;
#(
  parameter int data_width = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [data_width-1:0] din0,
  input  logic [data_width-1:0] din1,
  input  logic [data_width-1:0] din2,
  input  logic [data_width-1:0] din3,
  input  logic [data_width-1:0] din4,
  input  logic [data_width-1:0] din5,
  input  logic [data_width-1:0] din6,
  input  logic [data_width-1:0] din7,
  input  logic [data_width-1:0] din8,
  input  logic [data_width-1:0] din9,
  input  logic [data_width-1:0] din10,
  input  logic [data_width-1:0] din11,
  output logic                  out_valid,
  output logic [data_width-1:0] dout0,
  output logic [data_width-1:0] dout1,
  output logic [data_width-1:0] dout2,
  output logic [data_width-1:0] dout3,
  output logic [data_width-1:0] dout4,
  output logic [data_width-1:0] dout5,
  output logic [data_width-1:0] dout6,
  output logic [data_width-1:0] dout7,
  output logic [data_width-1:0] dout8,
  output logic [data_width-1:0] dout9,
  output logic [data_width-1:0] dout10,
  output logic [data_width-1:0] dout11
);
  logic [data_width-1:0] w_din [WINO_TILE];
  logic [data_width-1:0] w_d   [WINO_TILE];
  logic [data_width-1:0] w_u   [WINO_ROWS][WINO_COLS];
  logic [data_width-1:0] w_v   [WINO_TILE];
  logic                  w_valid;
  logic                  r_valid;
  logic [data_width-1:0] r_dout [WINO_TILE];

  assign w_din = '{din0, din1, din2, din3, din4, din5, din6, din7, din8, din9, din10, din11};

`ifdef WINO_BTDB_IN_REG_EN
  logic                  r_in_valid;
  logic [data_width-1:0] r_din [WINO_TILE];
  // input stage: tile captured only when valid so idle-bus X never enters the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_valid <= 1'b0;
      r_din      <= '{default: '0};
    end else begin
      r_in_valid <= in_valid;
      if (in_valid) r_din <= w_din;
    end
  end
  assign w_valid = r_in_valid;
  assign w_d     = r_din;
`else
  assign w_valid = in_valid;
  assign w_d     = w_din;
`endif

  genvar c, r;
  for (c = 0; c < WINO_COLS; c++) begin : g_col
    wino_bt4_1d #(.data_width(data_width)) u_bt4 (
      .i_d0(w_d[c]),
      .i_d1(w_d[WINO_COLS + c]),
      .i_d2(w_d[2*WINO_COLS + c]),
      .i_d3(w_d[3*WINO_COLS + c]),
      .o_u0(w_u[0][c]),
      .o_u1(w_u[1][c]),
      .o_u2(w_u[2][c]),
      .o_u3(w_u[3][c])
    );
  end
  for (r = 0; r < WINO_ROWS; r++) begin : g_row
    assign w_v[r*WINO_COLS]     = w_u[r][0] - w_u[r][1];
    assign w_v[r*WINO_COLS + 1] = w_u[r][1];
    assign w_v[r*WINO_COLS + 2] = w_u[r][2] - w_u[r][1];
  end

  // output stage: valid follows the pipeline, data loads only on a valid tile and holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dout  <= '{default: '0};
    end else begin
      r_valid <= w_valid;
      if (w_valid) r_dout <= w_v;
    end
  end

  assign out_valid = r_valid;
  assign dout0  = r_dout[0];
  assign dout1  = r_dout[1];
  assign dout2  = r_dout[2];
  assign dout3  = r_dout[3];
  assign dout4  = r_dout[4];
  assign dout5  = r_dout[5];
  assign dout6  = r_dout[6];
  assign dout7  = r_dout[7];
  assign dout8  = r_dout[8];
  assign dout9  = r_dout[9];
  assign dout10 = r_dout[10];
  assign dout11 = r_dout[11];
endmodule

// File: tb/tb_wino_btdb_22_32_xform.sv
// tb_wino_btdb_22_32_xform: directed vectors, random streaming against a matrix model, reset corners.
module tb_wino_btdb_22_32_xform;
  import wino_pkg::*;
  localparam int DW = 20;
  localparam int L  = WINO_LAT;
  typedef logic [WINO_TILE-1:0][DW-1:0] ptile_t;
  typedef struct packed { ptile_t d; ptile_t e; } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   in_valid = 1'b0;
  ptile_t din = '0;
  logic   out_valid;
  logic [DW-1:0] dout [WINO_TILE];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  wino_btdb_22_32_xform #(.data_width(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .din4(din[4]), .din5(din[5]), .din6(din[6]), .din7(din[7]),
    .din8(din[8]), .din9(din[9]), .din10(din[10]), .din11(din[11]),
    .out_valid(out_valid),
    .dout0(dout[0]), .dout1(dout[1]), .dout2(dout[2]), .dout3(dout[3]),
    .dout4(dout[4]), .dout5(dout[5]), .dout6(dout[6]), .dout7(dout[7]),
    .dout8(dout[8]), .dout9(dout[9]), .dout10(dout[10]), .dout11(dout[11])
  );

  // V = BT * D * B with the textbook matrices, integer arithmetic reduced mod 2^DW
  function automatic ptile_t model(input ptile_t d);
    int bt [4][4] = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
    int b  [3][3] = '{'{1, 0, 0}, '{-1, 1, -1}, '{0, 0, 1}};
    longint u [4][3];
    longint s;
    ptile_t v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) begin
        u[r][c] = 0;
        for (int k = 0; k < 4; k++) u[r][c] += longint'(bt[r][k]) * longint'(d[k*3+c]);
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += u[r][k] * longint'(b[k][c]);
        v[r*3+c] = s[DW-1:0];
      end
    return v;
  endfunction

  function automatic ptile_t rnd();
    ptile_t v;
    for (int i = 0; i < WINO_TILE; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic chk_tile(input string n, input ptile_t e);
    for (int i = 0; i < WINO_TILE; i++) chk($sformatf("%s dout%0d", n, i), dout[i], e[i]);
  endtask

  vec_t   tbl [4];
  ptile_t t;
  ptile_t last;
  ptile_t hd [16];
  logic   hv [16];

  initial begin
    for (int k = 0; k < 4; k++) begin
      tbl[k].d = '0;
      tbl[k].e = '0;
    end
    for (int i = 0; i < WINO_TILE; i++) tbl[0].d[i] = DW'(1);
    tbl[0].e[4] = DW'(2);
    tbl[1].d[4] = DW'(1);
    for (int i = 3; i < WINO_TILE; i++) tbl[1].e[i] = (i % 2 == 1) ? 20'hFFFFF : 20'h00001;
    tbl[2].d[1] = 20'h7FFFF;
    tbl[2].d[2] = 20'h00001;
    tbl[2].e[0] = 20'h80001;
    tbl[2].e[1] = 20'h7FFFF;
    tbl[2].e[2] = 20'h80002;
    tbl[3].d[0] = DW'(5);
    tbl[3].e[0] = DW'(5);

    rst_n = 1'b0;
    in_valid = 1'b1;
    din = rnd();
    repeat (3) @(negedge clk);
    chk("rst out_valid", DW'(out_valid), DW'(0));
    chk_tile("rst", '0);
    t = rnd();
    din = t;
    rst_n = 1'b1;
    repeat (L) @(negedge clk);
    chk("post-rst out_valid", DW'(out_valid), DW'(1));
    chk_tile("post-rst", model(t));
    in_valid = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      din = tbl[k].d;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      din = 'x;
      repeat (L - 1) @(negedge clk);
      chk($sformatf("vec%0d out_valid", k), DW'(out_valid), DW'(1));
      chk_tile($sformatf("vec%0d", k), tbl[k].e);
      @(negedge clk);
      chk($sformatf("vec%0d valid drop", k), DW'(out_valid), DW'(0));
      chk_tile($sformatf("vec%0d hold", k), tbl[k].e);
    end

    last = tbl[3].e;
    for (int c = 0; c < 12 + L; c++) begin
      if (c >= L) begin
        if (hv[c-L]) last = model(hd[c-L]);
        chk($sformatf("stream%0d out_valid", c), DW'(out_valid), DW'(hv[c-L]));
        chk_tile($sformatf("stream%0d", c), last);
      end
      hv[c] = (c < 10);
      hd[c] = rnd();
      in_valid = hv[c];
      din = hv[c] ? hd[c] : 'x;
      @(negedge clk);
    end

    in_valid = 1'b1;
    repeat (3) begin
      din = rnd();
      @(negedge clk);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", DW'(out_valid), DW'(0));
    chk_tile("midrst", '0);
    @(negedge clk);
    in_valid = 1'b0;
    din = 'x;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("no pulse %0d", c), DW'(out_valid), DW'(0));
    end
    chk_tile("post midrst", '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wino_btdb_22_32_xform.md
Name: wino_btdb_22_32_xform

Overview:
- Winograd input-tile transform V = B4^T · D · B3 for the mixed F(2x2, 3x2) convolution path.
- Input D is a 4-row x 3-column tile. Rows use the F(2,3) 4-point transform; columns use the F(2,2) 3-point transform.
- Sits between the input-tile buffer and the element-wise multiplier array.
- Fully pipelined: one tile per cycle, registered outputs.

Parameters:
- data_width, default 20: width of every din/dout element. Values are two's complement.

Ports:
- clk  input  1  system clock (rising edge)
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  din0..din11 carry a valid tile this cycle
- din0..din11  input  data_width each  tile element d[r][c], index = r*3+c (r=0..3, c=0..2)
- out_valid  output  1  dout0..dout11 hold a valid transformed tile
- dout0..dout11  output  data_width each  v[r][c], index = r*3+c

Behaviour:
- Reset: while rst_n=0 (asynchronous assert), out_valid=0 and all dout=0.
- Row pass, applied per column c:
  - u[0][c] = d0c - d2c
  - u[1][c] = d1c + d2c
  - u[2][c] = d2c - d1c
  - u[3][c] = d1c - d3c
- Column pass, applied per row r:
  - v[r][0] = u[r][0] - u[r][1]
  - v[r][1] = u[r][1]
  - v[r][2] = u[r][2] - u[r][1]
- Arithmetic:
  - All sums wrap modulo 2^data_width; no saturation, no width growth.
  - Results are truncated to data_width. This is bit-exact with an unbounded-integer computation reduced mod 2^data_width.
- Timing:
  - Latency is 1 cycle: inputs sampled on edge k appear on dout after edge k.
  - out_valid is in_valid delayed by 1 cycle.
- Handshake:
  - No backpressure; a new tile is accepted every cycle.
  - dout registers load only when in_valid=1 and otherwise hold their previous value.
  - out_valid drops to 0 one cycle after in_valid drops.
- Reset mid-stream: the in-flight tile is discarded, outputs clear to 0 immediately, and there is no out_valid pulse after release until a new in_valid.
- X/Z on din while in_valid=0 must not propagate to dout.

Optional Feature:
- Macro WINO_BTDB_IN_REG_EN.
- Defined:
  - An additional input register stage (din and in_valid) is added, also reset by rst_n.
  - Latency becomes 2 cycles, out_valid is delayed 2 cycles, and arithmetic is unchanged.
- Undefined: single-stage, latency 1 as above.

Decomposition:
- Package wino_pkg holds:
  - tile geometry constants: WINO_ROWS=4, WINO_COLS=3, WINO_TILE=12
  - the latency constant, which depends on the macro
- One natural sub-module, wino_bt4_1d: a combinational 4-point F(2,3) row transform, parameterised by data_width.
  - Instantiate it 3 times, once per column.
  - The 3-point column pass is written inline.

Test Plan:
- Reset:
  - Hold rst_n=0 with random din and in_valid=1, expect out_valid=0 and all dout=0.
  - Release, then after 1 cycle out_valid=1.
- All din=1, in_valid=1: next cycle dout4=2 and all other dout=0.
- din4=1, others 0:
  - dout3..dout11 = FFFFF,1,FFFFF, 1,FFFFF,1, FFFFF,1,FFFFF (hex, width 20).
  - dout0..2 = 0.
- Wrap test, din0=0, din1=0x7FFFF, din2=1, others 0: dout0=0x80001, dout1=0x7FFFF, dout2=0x80002, all others 0.
- Streaming with a software model:
  - Drive 10 random tiles back-to-back, then in_valid=0 for 2 cycles.
  - Each output tile must match the model bit-exact, 1 cycle later.
  - out_valid must go low and dout must hold its last value.
- Assert rst_n=0 mid-stream (not aligned to the clock edge):
  - Outputs clear immediately.
  - With WINO_BTDB_IN_REG_EN defined, rerun the streaming test and expect 2-cycle latency.
